// File: rtl/apb_timer_slave.sv
// APB timer responder: LOAD/VALUE/CTRL/STATUS registers and a prescaled
// down-counter that raises a level interrupt on underflow.
module apb_timer_slave #(
    parameter int WIDTH = 32
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             PSEL,
    input  logic             PENABLE,
    input  logic             PWRITE,
    input  logic [WIDTH-1:0] PADDR,
    input  logic [WIDTH-1:0] PWDATA,
    output logic [WIDTH-1:0] PRDATA,
    output logic             timer_irq
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] load_q, load_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [WIDTH-1:0] prdata_q, prdata_d;
    logic [15:0]      ctrl_q, ctrl_d;
    logic [7:0]       presc_q, presc_d;
    logic             raw_q, raw_d;

    logic             tick;
    logic             addr_ok;
    logic             wr_en;
    logic             rd_en;
    logic [1:0]       reg_sel;
    logic [WIDTH-1:0] rdata;
    logic             addr_unused;

    assign addr_unused = ^{PADDR[WIDTH-1:8], PADDR[1:0]};
    assign addr_ok     = (PADDR[7:4] == 4'h0);
    assign reg_sel     = PADDR[3:2];
    assign wr_en       = (state_q == SETUP) && PSEL && PENABLE && PWRITE && addr_ok;
    assign rd_en       = PSEL && !PENABLE && !PWRITE;
    assign tick        = ctrl_q[0] && (presc_q == ctrl_q[15:8]);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (PSEL && !PENABLE) state_d = SETUP;
            SETUP:   if (!PSEL) state_d = IDLE;
                     else if (PENABLE) state_d = ACCESS;
            ACCESS:  if (!PSEL) state_d = IDLE;
                     else if (!PENABLE) state_d = SETUP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata = '0;
        if (addr_ok) begin
            unique case (reg_sel)
                2'd0: rdata = load_q;
                2'd1: rdata = value_q;
                2'd2: rdata[15:0] = ctrl_q;
                2'd3: rdata[0] = raw_q;
                default: rdata = '0;
            endcase
        end
    end

    always_comb begin
        load_d   = load_q;
        value_d  = value_q;
        ctrl_d   = ctrl_q;
        raw_d    = raw_q;
        presc_d  = presc_q;
        prdata_d = prdata_q;

        if (ctrl_q[0]) presc_d = tick ? 8'd0 : presc_q + 8'd1;

        if (wr_en && reg_sel == 2'd3 && PWDATA[0]) raw_d = 1'b0;

        // Underflow is applied before bus writes so a same-edge write wins,
        // but it still sets RAW_IRQ over a STATUS clear.
        if (tick) begin
            if (value_q != '0) begin
                value_d = value_q - ONE;
            end else begin
                raw_d = 1'b1;
                if (ctrl_q[1]) value_d = load_q;
                else           ctrl_d[0] = 1'b0;
            end
        end

        if (wr_en && reg_sel == 2'd0) begin
            load_d  = PWDATA;
            value_d = PWDATA;
            presc_d = 8'd0;
        end

        if (wr_en && reg_sel == 2'd2) begin
            ctrl_d = PWDATA[15:0];
            if (!ctrl_q[0] && PWDATA[0]) presc_d = 8'd0;
        end

        if (rd_en) prdata_d = rdata;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= IDLE;
            load_q   <= '0;
            value_q  <= '0;
            ctrl_q   <= '0;
            raw_q    <= 1'b0;
            presc_q  <= '0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            load_q   <= load_d;
            value_q  <= value_d;
            ctrl_q   <= ctrl_d;
            raw_q    <= raw_d;
            presc_q  <= presc_d;
            prdata_q <= prdata_d;
        end
    end

    assign PRDATA    = prdata_q;
    assign timer_irq = raw_q & ctrl_q[2];

endmodule
